inequality_sweep_checker: RTL and testbench

Hardware self-checking driver for a 4-bit-in, 3-bit-out inequality/standard-form classifier. On start it drives every input value 0..15 onto the DUT, waits a programmable settle time, and samples the DUT's 3-bit output. It compares each sample against a golden table and reports pass/fail, the failure count and the first failing vector. It sits on the driving side of the classifier for on-board test, where a simulation bench is not available.

---
 rtl/inequality_sweep_checker_if.sv | 26 ++
 rtl/inequality_sweep_checker.sv | 117 +++++++++++
 tb/tb_inequality_sweep_checker.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inequality_sweep_checker_if.sv
// Bundles the sweep checker's control, stimulus and result signals.
// Latency: none, wiring only.
// Backpressure: none; start is a level request, results are held until restarted.
interface inequality_sweep_checker_if;
   logic       start;
   logic [2:0] dut_out;
   logic [3:0] num_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] fail_count;
   logic [3:0] first_fail_num;
   logic [2:0] first_fail_got;

   // Checker side: drives the classifier input and publishes results.
   modport master (
      input  start, dut_out,
      output num_out, busy, done, pass, fail_count, first_fail_num, first_fail_got
   );

   // Controller/classifier side: requests sweeps and returns classifier output.
   modport slave (
      output start, dut_out,
      input  num_out, busy, done, pass, fail_count, first_fail_num, first_fail_got
   );
endinterface

// File: rtl/inequality_sweep_checker.sv
// Sweeps NUM 0..15 into a 4-in/3-out classifier and checks each output against a golden table.
// Latency: 16*(SETTLE+1) cycles from the start edge to done.
// Backpressure: start is ignored while busy; results hold in DONE until start or reset.
module inequality_sweep_checker #(
   parameter logic [47:0] EXP_TABLE = {{6{3'b100}}, {6{3'b010}}, {4{3'b001}}},
   parameter int          SETTLE    = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   inequality_sweep_checker_if.master    bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Counter reload makes num_out stay put for exactly SETTLE cycles before CHECK.
   localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE - 1);

   state_t     state_q,    state_d;
   logic [3:0] num_q,      num_d;
   logic [7:0] cnt_q,      cnt_d;
   logic [4:0] fail_cnt_q, fail_cnt_d;
   logic [3:0] ff_num_q,   ff_num_d;
   logic [2:0] ff_got_q,   ff_got_d;

   logic [5:0] exp_idx;
   logic [2:0] exp_val;
   logic       mismatch;

   // State register: all sweep state, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         num_q      <= 4'd0;
         cnt_q      <= 8'd0;
         fail_cnt_q <= 5'd0;
         ff_num_q   <= 4'd0;
         ff_got_q   <= 3'd0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         cnt_q      <= cnt_d;
         fail_cnt_q <= fail_cnt_d;
         ff_num_q   <= ff_num_d;
         ff_got_q   <= ff_got_d;
      end
   end

   // Next-state: sequence the sweep and accumulate mismatch results.
   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      cnt_d      = cnt_q;
      fail_cnt_d = fail_cnt_q;
      ff_num_d   = ff_num_q;
      ff_got_d   = ff_got_q;

      // Golden entry for NUM=i lives at bits [3i+2:3i].
      exp_idx  = {1'b0, num_q, 1'b0} + {2'b00, num_q};
      exp_val  = EXP_TABLE[exp_idx +: 3];
      mismatch = (bus.dut_out != exp_val);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d    = ST_SETTLE;
               num_d      = 4'd0;
               cnt_d      = SETTLE_RELOAD;
               fail_cnt_d = 5'd0;
               ff_num_d   = 4'd0;
               ff_got_d   = 3'd0;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_CHECK: begin
            if (mismatch) begin
               // 16 vectors at most, so the 5-bit count cannot wrap.
               fail_cnt_d = fail_cnt_q + 5'd1;
               if (fail_cnt_q == 5'd0) begin
                  ff_num_d = num_q;
                  ff_got_d = bus.dut_out;
               end
            end
            if (num_q == 4'd15) begin
               state_d = ST_DONE;
            end else begin
               num_d   = num_q + 4'd1;
               cnt_d   = SETTLE_RELOAD;
               state_d = ST_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: status decoded from state, results straight from the flops.
   always_comb begin
      bus.busy           = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
      bus.done           = (state_q == ST_DONE);
      bus.pass           = (state_q == ST_DONE) && (fail_cnt_q == 5'd0);
      bus.num_out        = num_q;
      bus.fail_count     = fail_cnt_q;
      bus.first_fail_num = ff_num_q;
      bus.first_fail_got = ff_got_q;
   end

endmodule

// File: tb/tb_inequality_sweep_checker.sv
// Self-checking bench for the inequality sweep checker, SETTLE=1 and SETTLE=3 instances.
// Latency: expects done 16*(SETTLE+1) cycles after the start edge.
// Backpressure: exercises start while busy, start in DONE and start held high.
module tb_inequality_sweep_checker;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   // Classifier response per NUM value, shared by both instances.
   logic [2:0] tb_table [16];

   inequality_sweep_checker_if if1 ();
   inequality_sweep_checker_if if3 ();

   inequality_sweep_checker #(.SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   inequality_sweep_checker #(.SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural classifier in front of each checker.
   always_comb if1.dut_out = tb_table[if1.num_out];
   always_comb if3.dut_out = tb_table[if3.num_out];

   // Golden classification straight from the inequalities.
   function automatic logic [2:0] gold(int i);
      return {i > 9, (i >= 4) && (i <= 9), i < 4};
   endfunction

   // Reference result of a whole sweep over the current table.
   task automatic model(output int nf, output logic [3:0] fn, output logic [2:0] fg);
      nf = 0; fn = 4'd0; fg = 3'd0;
      for (int i = 0; i < 16; i++) begin
         if (tb_table[i] !== gold(i)) begin
            if (nf == 0) begin
               fn = 4'(i);
               fg = tb_table[i];
            end
            nf++;
         end
      end
   endtask

   task automatic set_golden();
      for (int i = 0; i < 16; i++) tb_table[i] = gold(i);
   endtask

   // Pulses start on the SETTLE=1 instance and counts cycles until done.
   task automatic run_sweep1(output int cycles, output bit busy_ok);
      if1.start = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      cycles = 0; busy_ok = 1'b1;
      while (!if1.done && cycles < 300) begin
         if (!if1.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; if1.start = 1'b0; if3.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({if1.num_out, if1.busy, if1.done, if1.pass, if1.fail_count,
           if1.first_fail_num, if1.first_fail_got} !== 19'd0) begin
         errors++;
         $display("FAIL reset_state1 got num=%0d busy=%0b done=%0b pass=%0b fc=%0d ffn=%0d ffg=%0d want all 0",
                  if1.num_out, if1.busy, if1.done, if1.pass, if1.fail_count,
                  if1.first_fail_num, if1.first_fail_got);
      end
      checks++;
      if ({if3.num_out, if3.busy, if3.done, if3.pass, if3.fail_count,
           if3.first_fail_num, if3.first_fail_got} !== 19'd0) begin
         errors++;
         $display("FAIL reset_state3 got busy=%0b done=%0b fc=%0d want all 0",
                  if3.busy, if3.done, if3.fail_count);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold got busy=%0b done=%0b want 0 0", if1.busy, if1.done);
      end
   endtask

   // Golden, stuck-at-000, single fault at NUM=3, then random fault tables.
   task automatic test_patterns();
      int cycles; bit busy_ok;
      int nf; logic [3:0] fn; logic [2:0] fg;
      for (int p = 0; p < 9; p++) begin
         set_golden();
         if (p == 1) begin
            for (int i = 0; i < 16; i++) tb_table[i] = 3'b000;
         end else if (p == 2) begin
            tb_table[3] = 3'b000;
         end else if (p >= 3) begin
            for (int i = 0; i < 16; i++)
               if ($urandom_range(0, 3) == 0) tb_table[i] = 3'($urandom_range(0, 7));
         end
         model(nf, fn, fg);
         run_sweep1(cycles, busy_ok);
         checks++;
         if (cycles !== 32 || !busy_ok) begin
            errors++;
            $display("FAIL sweep_len p=%0d got %0d cycles busy_ok=%0b want 32 1", p, cycles, busy_ok);
         end
         checks++;
         if (if1.done !== 1'b1 || if1.busy !== 1'b0 || if1.num_out !== 4'd15) begin
            errors++;
            $display("FAIL done_state p=%0d got done=%0b busy=%0b num=%0d want 1 0 15",
                     p, if1.done, if1.busy, if1.num_out);
         end
         checks++;
         if (if1.fail_count !== 5'(nf) || if1.pass !== (nf == 0)) begin
            errors++;
            $display("FAIL fail_count p=%0d got fc=%0d pass=%0b want fc=%0d pass=%0b",
                     p, if1.fail_count, if1.pass, nf, nf == 0);
         end
         checks++;
         if (if1.first_fail_num !== fn || if1.first_fail_got !== fg) begin
            errors++;
            $display("FAIL first_fail p=%0d got num=%0d val=%0d want num=%0d val=%0d",
                     p, if1.first_fail_num, if1.first_fail_got, fn, fg);
         end
      end
   endtask

   task automatic test_reset_midsweep();
      int cycles; bit busy_ok; int guard;
      set_golden();
      tb_table[2] = 3'b110;
      if1.start = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      guard = 0;
      while (if1.num_out != 4'd7 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++;
      if (if1.num_out !== 4'd7 || if1.busy !== 1'b1) begin
         errors++;
         $display("FAIL reach_num7 got num=%0d busy=%0b want 7 1", if1.num_out, if1.busy);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({if1.num_out, if1.busy, if1.done, if1.pass, if1.fail_count,
           if1.first_fail_num, if1.first_fail_got} !== 19'd0) begin
         errors++;
         $display("FAIL midsweep_reset got num=%0d busy=%0b done=%0b fc=%0d ffn=%0d want all 0",
                  if1.num_out, if1.busy, if1.done, if1.fail_count, if1.first_fail_num);
      end
      @(posedge clk); #1;
      checks++;
      if (if1.busy !== 1'b0 || if1.num_out !== 4'd0) begin
         errors++;
         $display("FAIL post_reset_idle got busy=%0b num=%0d want 0 0", if1.busy, if1.num_out);
      end
      set_golden();
      run_sweep1(cycles, busy_ok);
      checks++;
      if (cycles !== 32 || if1.pass !== 1'b1 || if1.fail_count !== 5'd0) begin
         errors++;
         $display("FAIL sweep_after_reset got cycles=%0d pass=%0b fc=%0d want 32 1 0",
                  cycles, if1.pass, if1.fail_count);
      end
   endtask

   task automatic test_start_while_busy();
      int cycles; bit injected;
      set_golden();
      tb_table[2] = 3'b101;
      if1.start = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      cycles = 0; injected = 1'b0;
      while (!if1.done && cycles < 300) begin
         if (if1.num_out == 4'd5 && !injected) begin
            if1.start = 1'b1; injected = 1'b1;
         end else begin
            if1.start = 1'b0;
         end
         @(posedge clk); #1;
         cycles++;
      end
      if1.start = 1'b0;
      checks++;
      if (cycles !== 32 || !injected) begin
         errors++;
         $display("FAIL busy_start_ignored got cycles=%0d injected=%0b want 32 1", cycles, injected);
      end
      @(posedge clk); #1;
      checks++;
      if (if1.done !== 1'b1 || if1.fail_count !== 5'd1 || if1.first_fail_num !== 4'd2 ||
          if1.first_fail_got !== 3'b101) begin
         errors++;
         $display("FAIL done_hold got done=%0b fc=%0d ffn=%0d ffg=%0d want 1 1 2 5",
                  if1.done, if1.fail_count, if1.first_fail_num, if1.first_fail_got);
      end
      if1.start = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      checks++;
      if (if1.done !== 1'b0 || if1.busy !== 1'b1 || if1.num_out !== 4'd0 ||
          if1.fail_count !== 5'd0 || if1.first_fail_num !== 4'd0 || if1.first_fail_got !== 3'd0) begin
         errors++;
         $display("FAIL restart_from_done got done=%0b busy=%0b num=%0d fc=%0d ffn=%0d ffg=%0d want 0 1 0 0 0 0",
                  if1.done, if1.busy, if1.num_out, if1.fail_count, if1.first_fail_num, if1.first_fail_got);
      end
      cycles = 0;
      while (!if1.done && cycles < 300) begin
         @(posedge clk); #1;
         cycles++;
      end
      checks++;
      if (cycles !== 32 || if1.fail_count !== 5'd1) begin
         errors++;
         $display("FAIL restart_sweep got cycles=%0d fc=%0d want 32 1", cycles, if1.fail_count);
      end
   endtask

   task automatic test_back_to_back();
      int cycles;
      set_golden();
      if1.start = 1'b1;
      @(posedge clk); #1;
      cycles = 0;
      while (!if1.done && cycles < 300) begin
         @(posedge clk); #1;
         cycles++;
      end
      checks++;
      if (cycles !== 32 || if1.pass !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first got cycles=%0d pass=%0b want 32 1", cycles, if1.pass);
      end
      @(posedge clk); #1;
      if1.start = 1'b0;
      checks++;
      if (if1.done !== 1'b0 || if1.busy !== 1'b1 || if1.num_out !== 4'd0 || if1.pass !== 1'b0) begin
         errors++;
         $display("FAIL b2b_restart got done=%0b busy=%0b num=%0d pass=%0b want 0 1 0 0",
                  if1.done, if1.busy, if1.num_out, if1.pass);
      end
      cycles = 0;
      while (!if1.done && cycles < 300) begin
         @(posedge clk); #1;
         cycles++;
      end
      checks++;
      if (cycles !== 32 || if1.pass !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second got cycles=%0d pass=%0b want 32 1", cycles, if1.pass);
      end
   endtask

   task automatic test_settle3();
      int num_bad; int busy_bad; int early_done;
      set_golden();
      if3.start = 1'b1;
      @(posedge clk); #1;
      if3.start = 1'b0;
      num_bad = 0; busy_bad = 0; early_done = 0;
      // Each NUM value should be visible for 4 cycles: 3 settle plus its check.
      for (int k = 0; k < 64; k++) begin
         if (if3.num_out !== 4'(k / 4)) num_bad++;
         if (if3.busy !== 1'b1) busy_bad++;
         if (if3.done !== 1'b0) early_done++;
         @(posedge clk); #1;
      end
      checks++;
      if (num_bad != 0) begin
         errors++;
         $display("FAIL settle3_num_timing got %0d off-schedule cycles want 0", num_bad);
      end
      checks++;
      if (busy_bad != 0 || early_done != 0) begin
         errors++;
         $display("FAIL settle3_busy got busy_low=%0d early_done=%0d want 0 0", busy_bad, early_done);
      end
      checks++;
      if (if3.done !== 1'b1 || if3.pass !== 1'b1 || if3.num_out !== 4'd15 || if3.fail_count !== 5'd0) begin
         errors++;
         $display("FAIL settle3_done got done=%0b pass=%0b num=%0d fc=%0d want 1 1 15 0",
                  if3.done, if3.pass, if3.num_out, if3.fail_count);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      if1.start = 1'b0;
      if3.start = 1'b0;
      set_golden();
      test_reset();
      test_patterns();
      test_reset_midsweep();
      test_start_while_busy();
      test_back_to_back();
      test_settle3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
